// File: rtl/sync_pla_pkg.sv
// Shared types and the single-row plane function for the synchronous PLA array.
// Vectors are evaluated at PLA_MAX_W bits; callers zero-extend narrower rows.
package sync_pla_pkg;

    localparam int PLA_MAX_W = 64;

    typedef enum logic [1:0] {
        PLA_AND  = 2'd0,
        PLA_OR   = 2'd1,
        PLA_NAND = 2'd2,
        PLA_NOR  = 2'd3
    } pla_mode_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } pla_state_e;

    // Zero-extended mask bits are "don't participate", so the extension is
    // neutral for both the AND and the OR reduction.
    function automatic logic pla_row_eval(
        input logic [PLA_MAX_W-1:0] mask,
        input logic [PLA_MAX_W-1:0] vec,
        input pla_mode_e            mode
    );
        logic and_r;
        logic or_r;
        logic res;
        and_r = &(vec | ~mask);
        or_r  = |(vec & mask);
        case (mode)
            PLA_AND:  res = and_r;
            PLA_OR:   res = or_r;
            PLA_NAND: res = ~and_r;
            PLA_NOR:  res = ~or_r;
            default:  res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/sync_pla_pers_mem.sv
// Personality row storage with sequential write pointer.
// SYNC_PLA_READBACK_EN adds a combinational row readback port.
module sync_pla_pers_mem
    import sync_pla_pkg::*;
#(
    parameter int N_IN  = 7,
    parameter int N_OUT = 3,
    localparam int AW   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    restart,
    input  logic                    wr_en,
    input  logic [N_IN-1:0]         wr_data,
`ifdef SYNC_PLA_READBACK_EN
    input  logic [AW-1:0]           rd_addr,
    output logic [N_IN-1:0]         rd_data,
`endif
    output logic                    last_row,
    output logic [N_OUT*N_IN-1:0]   rows_flat
);

    logic [AW-1:0] cnt_q;
    logic [AW-1:0] cnt_d;

    assign last_row = (cnt_q == AW'(N_OUT - 1));

    // Restart wins over a same-cycle write: the pointer returns to row 0 and
    // the colliding row is dropped.
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (wr_en) begin
            cnt_d = last_row ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Flops rather than RAM: the whole personality clears on reset.
    generate
        for (genvar gi = 0; gi < N_OUT; gi++) begin : g_row
            logic [N_IN-1:0] row_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    row_q <= '0;
                end else if (wr_en && !restart && (cnt_q == AW'(gi))) begin
                    row_q <= wr_data;
                end
            end

            assign rows_flat[gi*N_IN +: N_IN] = row_q;
        end
    endgenerate

`ifdef SYNC_PLA_READBACK_EN
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N_OUT; i++) begin
            if (rd_addr == AW'(i)) begin
                rd_data = rows_flat[i*N_IN +: N_IN];
            end
        end
    end
`endif

endmodule

// File: rtl/sync_pla_array.sv
// Synchronous PLA plane: streamed personality load, registered AND/OR/NAND/NOR evaluation.
// Define SYNC_PLA_READBACK_EN to expose rd_addr/rd_data row readback.
module sync_pla_array
    import sync_pla_pkg::*;
#(
    parameter int N_IN  = 7,
    parameter int N_OUT = 3,
    localparam int AW   = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              pers_valid,
    output logic              pers_ready,
    input  logic [N_IN-1:0]   pers_data,
    output logic              loaded,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   in_data,
    input  logic [1:0]        mode,
`ifdef SYNC_PLA_READBACK_EN
    input  logic [AW-1:0]     rd_addr,
    output logic [N_IN-1:0]   rd_data,
`endif
    output logic              out_valid,
    output logic [N_OUT-1:0]  out_data
);

    pla_state_e            state_q;
    pla_state_e            state_d;
    logic                  pers_hs;
    logic                  wr_en;
    logic                  accept;
    logic                  last_row;
    logic [N_OUT*N_IN-1:0] rows_flat;
    logic [N_OUT-1:0]      eval_vec;
    logic [N_OUT-1:0]      out_data_q;
    logic                  out_valid_q;

    assign pers_ready = (state_q == LOAD);
    assign in_ready   = (state_q == READY);
    assign loaded     = (state_q == READY);
    assign pers_hs    = pers_valid && pers_ready;
    assign wr_en      = pers_hs && !load_start;
    assign accept     = in_valid && in_ready;

    sync_pla_pers_mem #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT)
    ) u_mem (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart   (load_start),
        .wr_en     (wr_en),
        .wr_data   (pers_data),
`ifdef SYNC_PLA_READBACK_EN
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
`endif
        .last_row  (last_row),
        .rows_flat (rows_flat)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (load_start) state_d = LOAD;
            LOAD: begin
                if (load_start) begin
                    state_d = LOAD;
                end else if (pers_hs && last_row) begin
                    state_d = READY;
                end
            end
            READY: if (load_start) state_d = LOAD;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Evaluation reads the rows as they stand this cycle, so an accept that
    // coincides with load_start still sees the old personality.
    generate
        for (genvar gi = 0; gi < N_OUT; gi++) begin : g_eval
            assign eval_vec[gi] = pla_row_eval(PLA_MAX_W'(rows_flat[gi*N_IN +: N_IN]),
                                               PLA_MAX_W'(in_data),
                                               pla_mode_e'(mode));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= accept;
            if (accept) begin
                out_data_q <= eval_vec;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
